// File: rtl/seg7_decoder_monitor.sv
// seg7_decoder_monitor
//
// Watches an asynchronous, active-low 7-segment bus and recovers the hex digit
// shown on it. The bus is synchronized, debounced over STABLE_CYCLES clocks,
// decoded, checked against a counting sequence, and handed to a consumer
// through a valid/ready register.
//
// Ports:
//   clock        system clock, rising-edge active
//   reset        asynchronous active-low reset
//   seg_in[6:0]  active-low segment pattern (bit0 = a ... bit6 = g), async
//   value[3:0]   last accepted valid digit
//   value_valid  value holds a digit not yet transferred
//   value_ready  consumer takes value this cycle (ignored while !value_valid)
//   bad_code     one-cycle pulse: accepted pattern is not a hex digit
//   seq_error    one-cycle pulse: accepted digit breaks the count sequence
//   overrun      sticky: an untransferred digit was overwritten
//   err_count    saturating count of error events
//   clear_err    synchronous clear of err_count and overrun
module seg7_decoder_monitor #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] seg_in,
    output logic [3:0] value,
    output logic       value_valid,
    input  logic       value_ready,
    output logic       bad_code,
    output logic       seq_error,
    output logic       overrun,
    output logic [7:0] err_count,
    input  logic       clear_err
);

    localparam logic [6:0] SEG_ZERO = 7'h40;
    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES - 1);

    logic [6:0] sync1_q, sync2_q;
    logic [6:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] last_q, last_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       bad_q, bad_d;
    logic       seq_q, seq_d;
    logic       ovr_q, ovr_d;
    logic [7:0] err_q, err_d;

    logic       accept;
    logic       dec_ok;
    logic [3:0] dec_digit;
    logic       ovr_set;
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    // Pattern-to-digit table; anything not listed is a bad code.
    always_comb begin
        dec_ok    = 1'b1;
        dec_digit = 4'h0;
        unique case (cand_q)
            7'h40: dec_digit = 4'h0;
            7'h79: dec_digit = 4'h1;
            7'h24: dec_digit = 4'h2;
            7'h30: dec_digit = 4'h3;
            7'h19: dec_digit = 4'h4;
            7'h12: dec_digit = 4'h5;
            7'h02: dec_digit = 4'h6;
            7'h78: dec_digit = 4'h7;
            7'h00: dec_digit = 4'h8;
            7'h10: dec_digit = 4'h9;
            7'h08: dec_digit = 4'hA;
            7'h03: dec_digit = 4'hB;
            7'h46: dec_digit = 4'hC;
            7'h21: dec_digit = 4'hD;
            7'h06: dec_digit = 4'hE;
            7'h0E: dec_digit = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    // Debounce: the counter saturates, so comparing against last_accepted is
    // what keeps a held pattern from being accepted again every cycle.
    assign accept = (sync2_q == cand_q) && (cnt_q == CNT_MAX) && (cand_q != last_q);

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        prev_d  = prev_q;
        value_d = value_q;
        valid_d = valid_q;
        bad_d   = 1'b0;
        seq_d   = 1'b0;
        ovr_set = 1'b0;

        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        // A transfer clears valid; a valid accept below may set it again.
        if (valid_q && value_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            last_d = cand_q;
            if (!dec_ok) begin
                bad_d = 1'b1;
            end else begin
                // Digit 0 restarts the count, so it is never a sequence error.
                seq_d   = (dec_digit != 4'(prev_q + 4'd1)) && (dec_digit != 4'h0);
                ovr_set = valid_q && !value_ready;
                value_d = dec_digit;
                valid_d = 1'b1;
                prev_d  = dec_digit;
            end
        end

        ovr_d   = (clear_err ? 1'b0 : ovr_q) | ovr_set;
        err_inc = 2'({1'b0, bad_d} + {1'b0, seq_d} + {1'b0, ovr_set});
        err_sum = {1'b0, (clear_err ? 8'd0 : err_q)} + {7'd0, err_inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= SEG_ZERO;
            sync2_q <= SEG_ZERO;
            cand_q  <= SEG_ZERO;
            cnt_q   <= 8'd0;
            last_q  <= SEG_ZERO;
            prev_q  <= 4'h0;
            value_q <= 4'h0;
            valid_q <= 1'b0;
            bad_q   <= 1'b0;
            seq_q   <= 1'b0;
            ovr_q   <= 1'b0;
            err_q   <= 8'd0;
        end else begin
            sync1_q <= seg_in;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            prev_q  <= prev_d;
            value_q <= value_d;
            valid_q <= valid_d;
            bad_q   <= bad_d;
            seq_q   <= seq_d;
            ovr_q   <= ovr_d;
            err_q   <= err_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign bad_code    = bad_q;
    assign seq_error   = seq_q;
    assign overrun     = ovr_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_seg7_decoder_monitor.sv
// Self-checking bench for seg7_decoder_monitor (STABLE_CYCLES = 4).
module tb_seg7_decoder_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] seg_in = 7'h40;
    logic [3:0] value;
    logic       value_valid;
    logic       value_ready = 1'b0;
    logic       bad_code;
    logic       seq_error;
    logic       overrun;
    logic [7:0] err_count;
    logic       clear_err = 1'b0;

    seg7_decoder_monitor #(.STABLE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .seg_in      (seg_in),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .bad_code    (bad_code),
        .seq_error   (seq_error),
        .overrun     (overrun),
        .err_count   (err_count),
        .clear_err   (clear_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    typedef struct {
        logic [6:0] seg;
        int         digit;
    } vec_t;

    vec_t tbl[18];

    int tests  = 0;
    int failed = 0;

    // Observations gathered by apply().
    int n_valid, first_v, last_val, n_bad, n_seq;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive a pattern, then observe n clock edges (sampled 1 time unit after
    // each edge). Sample index k is edge k counted from the drive.
    task automatic apply(input logic [6:0] s, input int n, input logic rdy);
        seg_in      = s;
        value_ready = rdy;
        n_valid  = 0;
        first_v  = -1;
        last_val = -1;
        n_bad    = 0;
        n_seq    = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            if (value_valid === 1'b1) begin
                n_valid++;
                if (first_v < 0) first_v = k;
                last_val = int'(value);
            end
            if (bad_code === 1'b1) n_bad++;
            if (seq_error === 1'b1) n_seq++;
        end
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(posedge clock);
        #1;
        clear_err = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{7'h40, 0};
        tbl[1]  = '{7'h79, 1};
        tbl[2]  = '{7'h24, 2};
        tbl[3]  = '{7'h30, 3};
        tbl[4]  = '{7'h19, 4};
        tbl[5]  = '{7'h12, 5};
        tbl[6]  = '{7'h02, 6};
        tbl[7]  = '{7'h78, 7};
        tbl[8]  = '{7'h00, 8};
        tbl[9]  = '{7'h10, 9};
        tbl[10] = '{7'h08, 10};
        tbl[11] = '{7'h03, 11};
        tbl[12] = '{7'h46, 12};
        tbl[13] = '{7'h21, 13};
        tbl[14] = '{7'h06, 14};
        tbl[15] = '{7'h0E, 15};
        tbl[16] = '{7'h40, 0};
        tbl[17] = '{7'h79, 1};

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_value", int'(value), 0);
        check("rst_valid", int'(value_valid), 0);
        check("rst_bad", int'(bad_code), 0);
        check("rst_seq", int'(seq_error), 0);
        check("rst_ovr", int'(overrun), 0);
        check("rst_err", int'(err_count), 0);

        @(negedge clock);
        reset = 1'b1;

        // Held 40 after reset: no accept
        apply(7'h40, 10, 1'b1);
        check("hold40_valid", n_valid, 0);
        check("hold40_bad", n_bad, 0);

        // First digit: latency and value
        apply(7'h79, 10, 1'b1);
        check("first_latency", first_v, 6);
        check("first_nvalid", n_valid, 1);
        check("first_value", last_val, 1);
        check("first_bad", n_bad, 0);
        check("first_seq", n_seq, 0);
        check("first_err", int'(err_count), 0);

        // Count 0,1..F,0,1: each accepted once, in order, no sequence errors
        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].seg, 9, 1'b1);
            check($sformatf("step%0d_nvalid", i), n_valid, 1);
            check($sformatf("step%0d_value", i), last_val, tbl[i].digit);
            check($sformatf("step%0d_seq", i), n_seq, 0);
            check($sformatf("step%0d_bad", i), n_bad, 0);
        end
        check("count_err", int'(err_count), 0);

        // Two-clock glitch to 00, back to the accepted 79
        apply(7'h00, 2, 1'b1);
        check("glitch_valid", n_valid, 0);
        apply(7'h79, 12, 1'b1);
        check("glitch_after_valid", n_valid, 0);
        check("glitch_after_bad", n_bad, 0);
        check("glitch_after_seq", n_seq, 0);
        check("glitch_err", int'(err_count), 0);

        // Bad code, then 3 after 1, then 2 after 3
        apply(7'h7F, 9, 1'b1);
        check("bad_pulse", n_bad, 1);
        check("bad_valid", n_valid, 0);
        check("bad_value_kept", int'(value), 1);
        check("bad_err", int'(err_count), 1);
        apply(7'h30, 9, 1'b1);
        check("seq3_pulse", n_seq, 1);
        check("seq3_value", last_val, 3);
        check("seq3_err", int'(err_count), 2);
        apply(7'h24, 9, 1'b1);
        check("seq2_pulse", n_seq, 1);
        check("seq2_err", int'(err_count), 3);

        // Overrun with value_ready held low
        pulse_clear();
        check("clr_err", int'(err_count), 0);
        apply(7'h40, 9, 1'b1);
        check("ovr_zero_value", last_val, 0);
        apply(7'h79, 9, 1'b0);
        check("ovr_first_value", int'(value), 1);
        check("ovr_first_flag", int'(overrun), 0);
        apply(7'h24, 9, 1'b0);
        check("ovr_value", int'(value), 2);
        check("ovr_valid", int'(value_valid), 1);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_seq", n_seq, 0);
        check("ovr_err", int'(err_count), 1);
        pulse_clear();
        check("ovr_clr_flag", int'(overrun), 0);
        check("ovr_clr_err", int'(err_count), 0);
        check("ovr_clr_valid", int'(value_valid), 1);
        // 5 after 2 while still pending: sequence error plus overrun
        apply(7'h12, 9, 1'b0);
        check("dbl_seq", n_seq, 1);
        check("dbl_flag", int'(overrun), 1);
        check("dbl_err", int'(err_count), 2);

        // Reset mid-cycle while a digit is pending
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("async_valid", int'(value_valid), 0);
        check("async_ovr", int'(overrun), 0);
        check("async_err", int'(err_count), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // 300 bad-code events: count climbs, then saturates
        for (int i = 0; i < 300; i++) begin
            apply((i % 2 == 0) ? 7'h7F : 7'h7E, 8, 1'b1);
            if (i == 99) check("sat_mid", int'(err_count), 100);
        end
        check("sat_err", int'(err_count), 255);
        check("sat_valid", int'(value_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seg7_decoder_monitor.md
SEG7_DECODER_MONITOR -- requirements
Module: seg7_decoder_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..255: consecutive synchronized clocks a segment pattern must hold before it is accepted.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port seg_in  input  7  active-low 7-segment pattern, asynchronous to clock; bit0=segment a ... bit6=segment g.
REQ-005 SHALL have port value  output  4  decoded hex digit of the last accepted valid pattern.
REQ-006 SHALL have port value_valid  output  1  value holds an untransferred digit.
REQ-007 SHALL have port value_ready  input  1  consumer accepts value this cycle.
REQ-008 SHALL have port bad_code  output  1  one-cycle pulse: accepted pattern not in the decode table.
REQ-009 SHALL have port seq_error  output  1  one-cycle pulse: accepted digit breaks the count sequence.
REQ-010 SHALL have port overrun  output  1  sticky: a digit was overwritten before transfer.
REQ-011 SHALL have port err_count  output  8  saturating error-event count.
REQ-012 SHALL have port clear_err  input  1  synchronous clear of err_count and overrun.

Function
REQ-013 SHALL pass seg_in through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-014 SHALL decode (pattern hex -> digit): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F; any other pattern is a bad code.
REQ-015 SHALL hold a candidate pattern and stability counter: if sync2 != candidate, load candidate=sync2 and counter=0; otherwise increment counter, saturating at STABLE_CYCLES-1.
REQ-016 SHALL generate one accept event at the edge following counter==STABLE_CYCLES-1 with sync2==candidate, only if candidate != last_accepted; last_accepted is then updated to candidate.
REQ-017 SHALL give latency: seg_in changes before edge 0 and stays stable -> accept registered at edge STABLE_CYCLES+2 (edge 6 at default).
REQ-018 SHALL ignore glitches shorter than STABLE_CYCLES synchronized clocks: no accept, no flags.
REQ-019 SHALL, on accept of a valid code, load value, set value_valid, and update prev_digit.
REQ-020 SHALL, on accept of a bad code, pulse bad_code for one cycle and leave value, value_valid and prev_digit unchanged.
REQ-021 SHALL pulse seq_error on a valid accept whose digit != (prev_digit+1) mod 16 and != 0; digit 0 is always legal (counter reset), and F->0 is legal wrap.
REQ-022 SHALL transfer on value_valid && value_ready, clearing value_valid after that edge unless a new valid accept occurs in the same cycle, in which case value_valid stays 1 with the new digit and no overrun.
REQ-023 SHALL, on a valid accept while value_valid=1 and value_ready=0, overwrite value and set overrun.
REQ-024 SHALL increment err_count by the number of error conditions in a cycle (bad_code, seq_error, overrun-set; 0..2), saturating at 255.
REQ-025 SHALL, when clear_err=1, zero err_count and overrun; error events in the same cycle are then counted from 0 (e.g. count becomes 1).
REQ-026 SHALL keep value_ready ignored while value_valid=0.

Reset
REQ-027 SHALL, while reset=0, force sync1=sync2=candidate=last_accepted=7'h40, counter=0, prev_digit=0, value=0, value_valid=0, bad_code=0, seq_error=0, overrun=0, err_count=0.
REQ-028 SHALL, on reset assertion mid-operation, discard any pending digit immediately (value_valid=0 with no clock).
REQ-029 SHALL resume normal operation on the first rising edge after reset deasserts; a held 7'h40 produces no accept.

Verification
REQ-030 Bench SHALL drive 40 after reset, then 79 held 10 clocks, value_ready=1 -> value_valid pulse at edge 6, value=1, no flags.
REQ-031 Bench SHALL step patterns 1..F then 40 with value_ready=1 -> digits 1..F,0 in order, seq_error never asserts, err_count=0.
REQ-032 Bench SHALL glitch seg_in to 00 for 2 clocks, then return to stable 79 -> no accept, no flags.
REQ-033 Bench SHALL apply 7F (bad code), then 24 after 30 -> bad_code pulse with err_count=1, then seq_error on 3 following 1 with err_count=2.
REQ-034 Bench SHALL hold value_ready=0 and accept 1 then 2 -> value=2, overrun=1, err_count=1; clear_err pulse -> overrun=0, err_count=0.
REQ-035 Bench SHALL assert reset while value_valid=1 and drive 300 error events -> value_valid drops asynchronously; err_count saturates at 255.
